// File: rtl/aes_comp.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion,
// ready/valid style control (Krdy/Drdy in, Kvld/Dvld/BSY out).

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0 as required.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  logic [7:0] inv;

  assign inv = gf_inv(a);
  assign y   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_comp (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic         Krdy,
  input  logic [127:0] Din,
  input  logic         Drdy,
  input  logic         EncDec,
  output logic [127:0] Dout,
  output logic         Kvld,
  output logic         Dvld,
  output logic         BSY
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] key_reg;
  logic [127:0] rkey_reg;
  logic [127:0] state_reg;
  logic [3:0]   cnt_reg;
  logic [7:0]   rcon_reg;

  logic [15:0][7:0] sb_data;
  logic [3:0][7:0]  sb_key;
  logic [127:0]     sr_state;
  logic [127:0]     mc_state;
  logic [127:0]     next_rk;
  logic [127:0]     round_out;
  logic [31:0]      sub_rot;
  logic [31:0]      w0n, w1n, w2n, w3n;
  logic             last_round;

  // The core always encrypts; the mode input is accepted but has no effect.
  logic unused_encdec;
  assign unused_encdec = EncDec;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sb_data
      aes_sbox u_sbox (.a(state_reg[127-8*gi -: 8]), .y(sb_data[gi]));
      // Byte (row r, col c) takes SubBytes output from (r, c+r mod 4).
      assign sr_state[127-8*gi -: 8] = sb_data[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    end

    // Key S-boxes see RotWord(w3): byte k comes from w3 byte (k+1) mod 4.
    for (gi = 0; gi < 4; gi++) begin : g_sb_key
      aes_sbox u_sbox (.a(rkey_reg[31-8*((gi+1)%4) -: 8]), .y(sb_key[gi]));
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_state[127-32*gi -: 8];
      assign a1 = sr_state[119-32*gi -: 8];
      assign a2 = sr_state[111-32*gi -: 8];
      assign a3 = sr_state[103-32*gi -: 8];
      assign mc_state[127-32*gi -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
      };
    end
  endgenerate

  assign sub_rot    = {sb_key[0], sb_key[1], sb_key[2], sb_key[3]};
  assign w0n        = rkey_reg[127:96] ^ sub_rot ^ {rcon_reg, 24'h000000};
  assign w1n        = rkey_reg[95:64] ^ w0n;
  assign w2n        = rkey_reg[63:32] ^ w1n;
  assign w3n        = rkey_reg[31:0]  ^ w2n;
  assign next_rk    = {w0n, w1n, w2n, w3n};
  assign last_round = (cnt_reg == 4'd10);
  assign round_out  = (last_round ? sr_state : mc_state) ^ next_rk;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_reg   <= '0;
      rkey_reg  <= '0;
      state_reg <= '0;
      cnt_reg   <= '0;
      rcon_reg  <= '0;
      Dout      <= '0;
      Kvld      <= 1'b0;
      Dvld      <= 1'b0;
      BSY       <= 1'b0;
    end else if (EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      if (BSY) begin
        rkey_reg  <= next_rk;
        rcon_reg  <= xt(rcon_reg);
        state_reg <= round_out;
        if (last_round) begin
          Dout    <= round_out;
          Dvld    <= 1'b1;
          BSY     <= 1'b0;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end else if (Krdy) begin
        key_reg  <= Kin;
        rkey_reg <= Kin;
        Kvld     <= 1'b1;
      end else if (Drdy) begin
        state_reg <= Din ^ key_reg;
        rkey_reg  <= key_reg;
        rcon_reg  <= 8'h01;
        cnt_reg   <= 4'd1;
        BSY       <= 1'b1;
      end
    end else begin
      // Stalled: everything holds except the one-cycle strobes.
      Kvld <= 1'b0;
      Dvld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_comp.sv
// Directed + randomized bench for aes_comp, checked against FIPS-197 vectors and a
// table-driven AES-128 reference model built from the field definition.

module tb_aes_comp;

  logic         CLK;
  logic         RSTn;
  logic         EN;
  logic [127:0] Kin;
  logic         Krdy;
  logic [127:0] Din;
  logic         Drdy;
  logic         EncDec;
  logic [127:0] Dout;
  logic         Kvld;
  logic         Dvld;
  logic         BSY;

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_comp dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Kin(Kin), .Krdy(Krdy), .Din(Din),
    .Drdy(Drdy), .EncDec(EncDec), .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld), .BSY(BSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // Carry-less product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
            ^ {rc, 24'h000000};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_t[s[4*(((b/4) + (b%4)) % 4) + (b%4)]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          if (r < 10)
            s[4*c+j] = ref_mul(t[4*c+j], 8'h02) ^ ref_mul(t[4*c+(j+1)%4], 8'h03)
                     ^ t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
          else
            s[4*c+j] = t[4*c+j];
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) out[127-8*b -: 8] = s[b];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    Kin  = k;
    Krdy = 1'b1;
    step();
    Krdy = 1'b0;
    check("kvld on load", 128'(Kvld), 128'(1));
  endtask

  task automatic start(input logic [127:0] d);
    Din  = d;
    Drdy = 1'b1;
    step();
    Drdy = 1'b0;
    check("bsy on start", 128'(BSY), 128'(1));
  endtask

  // Steps until Dvld (bounded), then checks latency, result and BSY release.
  task automatic wait_done(input string tag, input logic [127:0] exp, input int exp_cycles);
    int n;
    bit seen;
    bit bsy_drop;
    n = 0;
    seen = 1'b0;
    bsy_drop = 1'b0;
    while (!seen && n < 60) begin
      step();
      n++;
      if (Dvld) seen = 1'b1;
      else if (!BSY) bsy_drop = 1'b1;
    end
    check({tag, " latency"}, 128'(n), 128'(exp_cycles));
    check({tag, " bsy held"}, 128'(bsy_drop), 128'(0));
    check({tag, " dout"}, Dout, exp);
    check({tag, " bsy end"}, 128'(BSY), 128'(0));
  endtask

  initial begin
    logic [127:0] k1, k2, k3, d1, d2, d3, d4, held;
    bit flag;

    RSTn = 1'b0; EN = 1'b1; Kin = '0; Krdy = 1'b0; Din = '0; Drdy = 1'b0; EncDec = 1'b0;
    build_sbox();
    check("model C1", aes_ref(K_C1, P_C1), C_C1);
    check("model B", aes_ref(K_B, P_B), C_B);

    repeat (3) step();
    check("reset dout", Dout, '0);
    check("reset kvld", 128'(Kvld), 128'(0));
    check("reset dvld", 128'(Dvld), 128'(0));
    check("reset bsy", 128'(BSY), 128'(0));
    RSTn = 1'b1;
    step();

    // FIPS-197 C.1, data request on the cycle right after the key request.
    load_key(K_C1);
    start(P_C1);
    check("c1 kvld single pulse", 128'(Kvld), 128'(0));
    wait_done("c1", C_C1, 10);
    step();
    check("c1 dvld single pulse", 128'(Dvld), 128'(0));
    check("c1 dout holds", Dout, C_C1);

    load_key(K_B);
    start(P_B);
    wait_done("fipsB", C_B, 10);

    // Key reuse, second request issued on the cycle BSY falls.
    load_key('0);
    start('0);
    wait_done("reuse1", C_Z, 10);
    start('0);
    wait_done("reuse2", C_Z, 10);

    for (int i = 0; i < 4; i++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      d1 = {$urandom, $urandom, $urandom, $urandom};
      load_key(k1);
      start(d1);
      wait_done("random", aes_ref(k1, d1), 10);
    end

    // Requests while busy are ignored; the key survives the block.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    load_key(k1);
    start(d1);
    Kin = k2; Krdy = 1'b1; Din = ~d1; Drdy = 1'b1;
    flag = 1'b0;
    repeat (3) begin
      step();
      if (Kvld) flag = 1'b1;
    end
    Krdy = 1'b0; Drdy = 1'b0;
    check("busy kvld", 128'(flag), 128'(0));
    wait_done("busy block", aes_ref(k1, d1), 7);
    flag = 1'b0;
    repeat (12) begin
      step();
      if (Dvld || BSY) flag = 1'b1;
    end
    check("busy no second block", 128'(flag), 128'(0));
    d2 = {$urandom, $urandom, $urandom, $urandom};
    start(d2);
    wait_done("key kept", aes_ref(k1, d2), 10);

    // Five stalled cycles mid-block.
    d3 = {$urandom, $urandom, $urandom, $urandom};
    start(d3);
    repeat (3) step();
    EN = 1'b0;
    repeat (5) step();
    check("stall bsy held", 128'(BSY), 128'(1));
    EN = 1'b1;
    wait_done("stall", aes_ref(k1, d3), 7);
    held = Dout;
    EN = 1'b0;
    step();
    check("en0 dvld forced", 128'(Dvld), 128'(0));
    check("en0 dout held", Dout, held);
    EN = 1'b1;
    step();

    // Krdy wins over Drdy in the same cycle.
    k3 = {$urandom, $urandom, $urandom, $urandom};
    d4 = {$urandom, $urandom, $urandom, $urandom};
    Kin = k3; Krdy = 1'b1; Din = d4; Drdy = 1'b1;
    step();
    Krdy = 1'b0; Drdy = 1'b0;
    check("prio kvld", 128'(Kvld), 128'(1));
    check("prio no start", 128'(BSY), 128'(0));
    step();
    check("prio still idle", 128'(BSY), 128'(0));
    start(d4);
    wait_done("prio", aes_ref(k3, d4), 10);

    // Asynchronous reset at round 5 clears everything including the key.
    start(d4);
    repeat (4) step();
    RSTn = 1'b0;
    #1;
    check("rst dout", Dout, '0);
    check("rst bsy", 128'(BSY), 128'(0));
    check("rst dvld", 128'(Dvld), 128'(0));
    check("rst kvld", 128'(Kvld), 128'(0));
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    step();
    start('0);
    wait_done("post reset zero key", C_Z, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_comp.md
# aes_comp

Iterative AES-128 encryption core: one 128-bit block per 11 clock cycles, one round per clock. On-the-fly key expansion. Sits behind a simple ready/valid handshake as the cipher engine of a crypto peripheral. Variants differ only in S-box realisation (composite-field, PPRM one-stage, PPRM three-stage); all share this interface and timing.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock.
- RSTn  in  1  asynchronous, active-low reset.
- EN  in  1  global enable; 0 stalls the core.
- Kin  in  128  cipher key; bits 127:120 = key byte 0 (FIPS-197 order).
- Krdy  in  1  key-load request.
- Din  in  128  plaintext block; bits 127:120 = byte 0.
- Drdy  in  1  data-start request.
- EncDec  in  1  mode select.
  - Only 0 (encrypt) is supported.
  - The value is ignored; the core always encrypts.
  - Integrators tie it to 0.
- Dout  out  128  ciphertext, registered, same byte order.
- Kvld  out  1  one-cycle pulse: key accepted.
- Dvld  out  1  one-cycle pulse: Dout valid.
- BSY  out  1  high while a block is being encrypted.

## Operation
- Registers:
  - key register: master key.
  - round-key register.
  - state register.
  - round counter (1..10).
  - Rcon register.
  - Dout, Kvld, Dvld, BSY.
- Key load: at an edge with EN=1, BSY=0, Krdy=1:
  - key register and round-key register load Kin.
  - Kvld=1 for the following cycle.
  - Krdy held high reloads the key every cycle and keeps Kvld high.
- Data start: at an edge with EN=1, BSY=0, Krdy=0, Drdy=1:
  - state <= Din XOR key register.
  - round-key <= key register; Rcon <= 0x01; counter <= 1; BSY <= 1.
- Round r (1..10), one per edge while BSY=1 and EN=1:
  - Next round key = KeyExpand(current round key, Rcon): w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Rounds 1–9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next round key.
  - Round 10: MixColumns is omitted.
  - Rcon <= xtime(Rcon), giving 01,02,04,08,10,20,40,80,1b,36.
- After round 10:
  - Dout <= result; Dvld=1 for one cycle; BSY <= 0; counter idle.
- Datapath details:
  - State is column-major: byte i sits at bits 127-8i : 120-8i; column c = bytes 4c..4c+3.
  - S-box is the AES S-box: GF(2^8) inverse mod x^8+x^4+x^3+x+1, then affine transform with constant 0x63.
  - 20 S-box instances: 16 for data, 4 for the key schedule. Any gate-level realisation is acceptable.
  - MixColumns uses the standard {02,03,01,01} circulant over GF(2^8).
- Key register is unchanged by encryption, so multiple blocks can use one key load.
- Priority and ignored requests:
  - Krdy has priority over Drdy in the same cycle; that Drdy is dropped.
  - Krdy and Drdy while BSY=1 are ignored. The key is not changed mid-block.
- EN=0:
  - All registers hold (state, counter, keys, Dout, BSY).
  - Kvld and Dvld are forced to 0.
  - Operation resumes on the first edge after EN returns to 1.
- Reset (async, any time, including mid-block):
  - Dout=0, Kvld=0, Dvld=0, BSY=0.
  - counter, state, round-key and key register = 0.
  - An in-flight block is discarded.

## Timing
- Krdy sampled at edge K → Kvld high during cycle K..K+1. Drdy is acceptable at edge K+1.
- Drdy sampled at edge N → BSY high from edge N to edge N+10.
- Dout/Dvld update at edge N+10; Dvld is high from edge N+10 to edge N+11.
- Latency is 10 cycles from the Drdy edge to Dvld. Throughput is one block per 11 cycles.
- A new Drdy is accepted at edge N+11 or later (BSY=0 from N+10).
- Dout holds its value until the next block completes or reset.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- FIPS-197 C.1: Krdy with Kin=000102030405060708090a0b0c0d0e0f, next cycle Drdy with Din=00112233445566778899aabbccddeeff.
  - Kvld pulses once.
  - BSY high 10 cycles.
  - Dvld pulses 10 cycles after Drdy with Dout=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 B: Kin=2b7e151628aed2a6abf7158809cf4f3c, Din=3243f6a8885a308d313198a2e0370734 → Dout=3925841d02dc09fbdc118597196a0b32.
- Key reuse: one key load of all-zero, then two back-to-back blocks of all-zero data.
  - Second Drdy issued the cycle BSY falls.
  - Both give Dout=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Busy rejection: during block 1, assert Krdy with a different key and pulse Drdy.
  - No Kvld.
  - Block 1 result is unaffected.
  - No second Dvld.
- Stall and priority:
  - EN=0 for 5 cycles mid-block → Dvld delayed exactly 5 cycles, Dout still correct.
  - Krdy and Drdy in the same cycle → key loaded, no encryption starts.
- Reset mid-block: pull RSTn low at round 5.
  - Outputs are 0 immediately.
  - After release, a Drdy without a new key encrypts under the all-zero key: Din=0 → 66e94bd4ef8a2c3b884cfa59ca342b2e.
